// File: rtl/riscv_multicycle.sv
// Multi-cycle RV64 subset core: add/sub/and/or, ld, sd, beq over FETCH/DECODE/EXEC/MEM/WB.
// Define RISCV_MC_ITYPE_EN to also execute addi/andi/ori (opcode 0010011); otherwise it halts.
module riscv_multicycle #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     IMEM_AW  = 8,
  parameter int unsigned     DMEM_AW  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [XLEN-1:0]    pc,
  output logic               retire,
  output logic               halt
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef RISCV_MC_ITYPE_EN
  localparam logic [6:0] OP_I   = 7'b0010011;
`endif

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, res_q, res_d;
  logic [XLEN-1:0] rf_q [32];
  logic            rf_we;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1_idx, rs2_idx;
  logic [2:0]      funct3;
  logic            is_r, is_ld, is_sd, is_beq, is_i, op_legal;
  logic            fetch_done, mem_done;
  logic [XLEN-1:0] imm_dec, op_b, alu_out;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];

  assign is_r   = (opcode == OP_R);
  assign is_ld  = (opcode == OP_LD);
  assign is_sd  = (opcode == OP_SD);
  assign is_beq = (opcode == OP_BEQ);
`ifdef RISCV_MC_ITYPE_EN
  assign is_i   = (opcode == OP_I);
`else
  assign is_i   = 1'b0;
`endif
  assign op_legal = is_r | is_ld | is_sd | is_beq | is_i;

  assign fetch_done = imem_req & imem_ack;
  assign mem_done   = dmem_req & dmem_ack;

  // Sign-extended immediate: I format by default, S and B by opcode
  always_comb begin
    imm_dec = XLEN'($signed(ir_q[31:20]));
    if (is_sd) begin
      imm_dec = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
    end else if (is_beq) begin
      imm_dec = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    end
  end

  // ld/sd carry funct3=011 and fall through to the adder for address generation
  always_comb begin
    op_b = is_r ? rs2_q : imm_q;
    case (funct3)
      3'b111:  alu_out = rs1_q & op_b;
      3'b110:  alu_out = rs1_q | op_b;
      default: alu_out = (is_r && ir_q[30]) ? (rs1_q - op_b) : (rs1_q + op_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = op_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_beq)              state_d = S_FETCH;
        else if (is_ld || is_sd) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM:    if (mem_done) state_d = is_sd ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Requests, retire and halt are suppressed while rst is high so a reset cycle is always idle
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    retire   = 1'b0;
    halt     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXEC:  retire   = is_beq;
        S_MEM: begin
          dmem_req = 1'b1;
          retire   = is_sd & dmem_ack;
        end
        S_WB:    retire   = 1'b1;
        S_HALT:  halt     = 1'b1;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign dmem_we    = dmem_req & is_sd;
  assign dmem_addr  = res_q[DMEM_AW-1:0];
  assign dmem_wdata = rs2_q;
  assign pc         = pc_q;

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    imm_d = imm_q;
    res_d = res_q;
    rf_we = 1'b0;
    case (state_q)
      S_FETCH: if (fetch_done) ir_d = imem_rdata;
      S_DECODE: begin
        rs1_d = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
        rs2_d = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
        imm_d = imm_dec;
      end
      S_EXEC: begin
        if (is_beq) pc_d = pc_q + ((rs1_q == rs2_q) ? imm_q : XLEN'(4));
        else        res_d = alu_out;
      end
      S_MEM: begin
        if (mem_done) begin
          if (is_sd) pc_d  = pc_q + XLEN'(4);
          else       res_d = dmem_rdata;
        end
      end
      S_WB: begin
        pc_d  = pc_q + XLEN'(4);
        rf_we = (rd != 5'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
      res_q <= res_d;
    end
  end

  // Register file keeps its contents across reset; x0 is never written
  always_ff @(posedge clk) begin
    if (rf_we && !rst) rf_q[rd] <= res_q;
  end
endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: instruction table plus hand sequences for wait states,
// reset during MEM, illegal opcode and the optional I-type (RISCV_MC_ITYPE_EN).
`timescale 1ns/1ps
module tb_riscv_multicycle;
  localparam int unsigned     XLEN    = 64;
  localparam int unsigned     IMEM_AW = 8;
  localparam int unsigned     DMEM_AW = 8;
  localparam logic [XLEN-1:0] RST_PC  = 64'h40;
  localparam int              NV      = 19;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halt;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [XLEN-1:0]    dmem_wdata, dmem_rdata, pc;

  logic [31:0]        imem [256];
  logic [XLEN-1:0]    dmem [256];
  bit                 tie_ack;
  int                 imem_lat, dmem_lat, imem_wait, dmem_wait;
  logic [DMEM_AW-1:0] st_addr;
  logic [XLEN-1:0]    st_data;
  int                 st_cnt, retire_cnt, checks, errors;

  typedef struct {
    logic [31:0]        instr;
    logic [XLEN-1:0]    addr;
    int                 cyc;
    logic [XLEN-1:0]    pc_after;
    bit                 st;
    logic [DMEM_AW-1:0] st_a;
    logic [XLEN-1:0]    st_d;
  } vec_t;
  vec_t vt [NV];

  riscv_multicycle #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halt(halt)
  );

  initial forever #5 clk = ~clk;

  assign imem_ack   = tie_ack | (imem_req && (imem_wait >= imem_lat));
  assign dmem_ack   = tie_ack | (dmem_req && (dmem_wait >= dmem_lat));
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (rst) begin
      imem_wait <= 0;
      dmem_wait <= 0;
    end else begin
      imem_wait <= (imem_req && !imem_ack) ? imem_wait + 1 : 0;
      dmem_wait <= (dmem_req && !dmem_ack) ? dmem_wait + 1 : 0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Two reset edges, then release; returns at the sample point of the first cycle after rst falls
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_pc", pc, RST_PC);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", 64'(imem_req), 64'd1);
    chk("post_rst_imem_addr", 64'(imem_addr), 64'h10);
  endtask

  // Runs one instruction from its FETCH cycle; returns one cycle after retire (or halt)
  task automatic run_instr(output int cyc, output int dreq_cyc, output bit retired, output bit halted);
    logic [DMEM_AW-1:0] a0;
    logic [XLEN-1:0]    w0;
    logic               we0;
    bit                 stable, excl;
    cyc = 0; dreq_cyc = 0; retired = 0; halted = 0; stable = 1; excl = 1;
    a0 = '0; w0 = '0; we0 = 1'b0;
    while (cyc < 40 && !retired && !halted) begin
      cyc++;
      if (imem_req && dmem_req) excl = 0;
      if (dmem_req) begin
        if (dreq_cyc == 0) begin
          a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we;
        end else if (a0 !== dmem_addr || w0 !== dmem_wdata || we0 !== dmem_we) begin
          stable = 0;
        end
        dreq_cyc++;
      end
      if (dmem_req && dmem_ack && dmem_we) begin
        dmem[dmem_addr] = dmem_wdata;
        st_addr = dmem_addr;
        st_data = dmem_wdata;
        st_cnt++;
      end
      if (retire) begin
        retired = 1;
        retire_cnt++;
      end
      if (halt) halted = 1;
      @(posedge clk); #2;
    end
    chk("req_exclusive", 64'(excl), 64'd1);
    chk("dmem_stable", 64'(stable), 64'd1);
  endtask

  initial begin
    int cyc, dq, st0, rc0;
    bit ret, hl, bad;
    rst = 1'b1; tie_ack = 1'b1; imem_lat = 0; dmem_lat = 0;
    st_cnt = 0; retire_cnt = 0; checks = 0; errors = 0;
    st_addr = '0; st_data = '0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'hFFFF_FFFF;
      dmem[i] = '0;
    end
    dmem[8]  = 64'd7;
    dmem[16] = 64'd3;
    dmem[24] = 64'hF0F0_0000_FFFF_1234;

    vt[0]  = '{enc_ld(5'd5, 5'd0, 12'd8),                    64'h40, 5, 64'h44, 1'b0, 8'd0,  64'd0};
    vt[1]  = '{enc_ld(5'd6, 5'd0, 12'd8),                    64'h44, 5, 64'h48, 1'b0, 8'd0,  64'd0};
    vt[2]  = '{enc_ld(5'd8, 5'd0, 12'd16),                   64'h48, 5, 64'h4C, 1'b0, 8'd0,  64'd0};
    vt[3]  = '{enc_beq(5'd5, 5'd6, 13'd8),                   64'h4C, 3, 64'h54, 1'b0, 8'd0,  64'd0};
    vt[4]  = '{enc_beq(5'd5, 5'd8, 13'd8),                   64'h54, 3, 64'h58, 1'b0, 8'd0,  64'd0};
    vt[5]  = '{enc_r(7'h00, 3'b000, 5'd9, 5'd5, 5'd8),       64'h58, 4, 64'h5C, 1'b0, 8'd0,  64'd0};
    vt[6]  = '{enc_sd(5'd9, 5'd0, 12'd32),                   64'h5C, 4, 64'h60, 1'b1, 8'd32, 64'd10};
    vt[7]  = '{enc_r(7'h20, 3'b000, 5'd10, 5'd8, 5'd5),      64'h60, 4, 64'h64, 1'b0, 8'd0,  64'd0};
    vt[8]  = '{enc_sd(5'd10, 5'd0, 12'd40),                  64'h64, 4, 64'h68, 1'b1, 8'd40, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[9]  = '{enc_ld(5'd11, 5'd0, 12'd24),                  64'h68, 5, 64'h6C, 1'b0, 8'd0,  64'd0};
    vt[10] = '{enc_r(7'h00, 3'b111, 5'd12, 5'd11, 5'd10),    64'h6C, 4, 64'h70, 1'b0, 8'd0,  64'd0};
    vt[11] = '{enc_sd(5'd12, 5'd0, 12'd48),                  64'h70, 4, 64'h74, 1'b1, 8'd48, 64'hF0F0_0000_FFFF_1234};
    vt[12] = '{enc_r(7'h00, 3'b110, 5'd13, 5'd11, 5'd8),     64'h74, 4, 64'h78, 1'b0, 8'd0,  64'd0};
    vt[13] = '{enc_sd(5'd13, 5'd0, 12'd56),                  64'h78, 4, 64'h7C, 1'b1, 8'd56, 64'hF0F0_0000_FFFF_1237};
    vt[14] = '{enc_r(7'h00, 3'b000, 5'd0, 5'd5, 5'd6),       64'h7C, 4, 64'h80, 1'b0, 8'd0,  64'd0};
    vt[15] = '{enc_sd(5'd0, 5'd0, 12'd64),                   64'h80, 4, 64'h84, 1'b1, 8'd64, 64'd0};
    vt[16] = '{enc_sd(5'd5, 5'd9, 12'hFF8),                  64'h84, 4, 64'h88, 1'b1, 8'd2,  64'd7};
    vt[17] = '{enc_beq(5'd0, 5'd0, 13'h1FF8),                64'h88, 3, 64'h80, 1'b0, 8'd0,  64'd0};
    vt[18] = '{enc_sd(5'd0, 5'd0, 12'd64),                   64'h80, 4, 64'h84, 1'b1, 8'd64, 64'd0};
    for (int i = 0; i < NV; i++) imem[vt[i].addr[9:2]] = vt[i].instr;

    // Table: zero-wait memories with both acks tied high
    do_reset();
    for (int i = 0; i < NV; i++) begin
      st0 = st_cnt;
      chk($sformatf("row%0d_pc_start", i), pc, vt[i].addr);
      run_instr(cyc, dq, ret, hl);
      chk($sformatf("row%0d_retired", i), 64'(ret), 64'd1);
      chk($sformatf("row%0d_cycles", i), 64'(cyc), 64'(vt[i].cyc));
      chk($sformatf("row%0d_pc_next", i), pc, vt[i].pc_after);
      if (vt[i].st) begin
        chk($sformatf("row%0d_st_cnt", i), 64'(st_cnt), 64'(st0 + 1));
        chk($sformatf("row%0d_st_addr", i), 64'(st_addr), 64'(vt[i].st_a));
        chk($sformatf("row%0d_st_data", i), st_data, vt[i].st_d);
      end else begin
        chk($sformatf("row%0d_no_store", i), 64'(st_cnt), 64'(st0));
      end
    end
    chk("retire_total", 64'(retire_cnt), 64'(NV));

    // Wait states: dmem ack 3 cycles late, then imem ack 2 cycles late; x5 survives reset
    tie_ack = 1'b0;
    imem[8'h10] = enc_sd(5'd5, 5'd0, 12'd0);
    imem[8'h11] = enc_ld(5'd7, 5'd0, 12'd0);
    imem[8'h12] = enc_sd(5'd7, 5'd0, 12'd80);
    dmem[0] = '0;
    dmem_lat = 3;
    do_reset();
    run_instr(cyc, dq, ret, hl);
    chk("slow_sd_cycles", 64'(cyc), 64'd7);
    chk("slow_sd_dreq", 64'(dq), 64'd4);
    chk("slow_sd_data", st_data, 64'd7);
    run_instr(cyc, dq, ret, hl);
    chk("slow_ld_cycles", 64'(cyc), 64'd8);
    chk("slow_ld_dreq", 64'(dq), 64'd4);
    chk("slow_ld_pc", pc, 64'h48);
    dmem_lat = 0;
    imem_lat = 2;
    run_instr(cyc, dq, ret, hl);
    chk("slow_fetch_cycles", 64'(cyc), 64'd6);
    chk("slow_fetch_st_addr", 64'(st_addr), 64'd80);
    chk("slow_fetch_x7", st_data, 64'd7);
    imem_lat = 0;

    // Reset in MEM with ack high: the load into x7 must be dropped
    tie_ack = 1'b1;
    imem[8'h10] = enc_ld(5'd7, 5'd0, 12'd16);
    do_reset();
    repeat (3) begin
      @(posedge clk); #2;
    end
    chk("mem_reached", 64'(dmem_req), 64'd1);
    rc0 = retire_cnt;
    rst = 1'b1;
    #1;
    chk("mem_rst_retire", 64'(retire), 64'd0);
    chk("mem_rst_dmem_req", 64'(dmem_req), 64'd0);
    imem[8'h10] = enc_sd(5'd7, 5'd0, 12'd88);
    do_reset();
    run_instr(cyc, dq, ret, hl);
    chk("mem_rst_x7_kept", st_data, 64'd7);
    chk("mem_rst_retire_cnt", 64'(retire_cnt), 64'(rc0 + 1));

    // Illegal opcode halts after DECODE and stays halted until reset
    imem[8'h10] = 32'h0000_007F;
    do_reset();
    run_instr(cyc, dq, ret, hl);
    chk("illegal_halted", 64'(hl), 64'd1);
    chk("illegal_cycles", 64'(cyc), 64'd3);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (imem_req || dmem_req || !halt || retire) bad = 1;
      @(posedge clk); #2;
    end
    chk("halt_absorbing", 64'(bad), 64'd0);

    // addi x5,x0,-1: halts by default, executes when the I-type option is built in
    imem[8'h10] = enc_addi(5'd5, 5'd0, 12'hFFF);
    imem[8'h11] = enc_sd(5'd5, 5'd0, 12'd96);
    do_reset();
    chk("halt_cleared", 64'(halt), 64'd0);
    run_instr(cyc, dq, ret, hl);
`ifdef RISCV_MC_ITYPE_EN
    chk("addi_retired", 64'(ret), 64'd1);
    chk("addi_cycles", 64'(cyc), 64'd4);
    run_instr(cyc, dq, ret, hl);
    chk("addi_x5", st_data, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("addi_halted", 64'(hl), 64'd1);
    chk("addi_cycles", 64'(cyc), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_multicycle.md
RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 64; datapath and register width (32 or 64).
REQ-002 SHALL have parameter IMEM_AW, default 8; instruction-memory word-address width.
REQ-003 SHALL have parameter DMEM_AW, default 8; data-memory address width.
REQ-004 SHALL have parameter RESET_PC, default 0; PC value loaded on reset.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port imem_req  out  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  out  IMEM_AW  fetch word address = pc[IMEM_AW+1:2].
REQ-009 SHALL have port imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata  in  32  instruction word.
REQ-011 SHALL have port dmem_req  out  1  data access request.
REQ-012 SHALL have port dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-013 SHALL have port dmem_addr  out  DMEM_AW  ALU result [DMEM_AW-1:0].
REQ-014 SHALL have port dmem_wdata  out  XLEN  rs2 value for stores.
REQ-015 SHALL have port dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle for loads.
REQ-016 SHALL have port dmem_rdata  in  XLEN  load data.
REQ-017 SHALL have port pc  out  XLEN  current PC, byte address.
REQ-018 SHALL have port retire  out  1  one-cycle pulse per completed instruction.
REQ-019 SHALL have port halt  out  1  high, and held high, after an illegal opcode.

Function
REQ-020 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-021 FETCH: imem_req SHALL be held at 1 until imem_ack; on ack, latch IR and go to DECODE; ack is accepted in the same cycle it first appears.
REQ-022 DECODE: SHALL latch rs1 and rs2 values and the sign-extended immediate (I, S and B formats) to XLEN; an unsupported opcode -> HALT.
REQ-023 Supported opcodes: 0110011 (add, sub, and, or), 0000011 (ld), 0100011 (sd), 1100011 (beq), plus 0010011 per REQ-036.
REQ-024 EXEC, beq: pc <= (rs1==rs2) ? pc+imm : pc+4; retire; -> FETCH.
REQ-025 EXEC, R/I-type: -> WB. EXEC, ld/sd: compute address rs1+imm; -> MEM.
REQ-026 MEM: dmem_req SHALL be held until dmem_ack, with dmem_addr, dmem_we and dmem_wdata stable; on ack, sd: pc+4, retire, -> FETCH; ld: latch dmem_rdata, -> WB.
REQ-027 WB: write the result to rd, except that writes to x0 SHALL be dropped (x0 reads 0); pc <= pc+4; retire; -> FETCH.
REQ-028 With zero-wait acks, latency SHALL be: beq 3 cycles, sd 4 cycles, R/I-type 4 cycles, ld 5 cycles.
REQ-029 All arithmetic SHALL be modulo 2^XLEN; PC wrap past 2^XLEN-4 SHALL go to 0; imem_addr and dmem_addr SHALL truncate silently.
REQ-030 HALT: SHALL be absorbing until rst; imem_req=0, dmem_req=0, halt=1, retire=0.
REQ-031 imem_req and dmem_req SHALL never be high in the same cycle.
REQ-032 An ack arriving while the corresponding req is low SHALL be ignored.

Reset
REQ-033 rst=1 at a clock edge SHALL set: state=FETCH, pc=RESET_PC, retire=0, halt=0, imem_req=0 and dmem_req=0 during the reset cycle; imem_req=1 in the first cycle after rst falls.
REQ-034 rst during MEM or FETCH SHALL abandon the access; no register write, no retire, and an ack coinciding with rst is ignored.
REQ-035 Register-file contents SHALL NOT be reset, except x0, which always reads 0.

Configuration
REQ-036 Macro RISCV_MC_ITYPE_EN: when defined, opcode 0010011 (addi, andi, ori) executes with ALU operand B = imm; when undefined, 0010011 is illegal -> HALT.

Verification
REQ-037 Reset, RESET_PC=0x40, acks tied to 1 -> pc=0x40, first imem_addr=0x10, retire on the 4th cycle for an add.
REQ-038 x5=7, x6=7, beq x5,x6,+8 at pc=0 -> pc=8, retire after 3 cycles; with x6=3 -> pc=4.
REQ-039 sd x5,0(x0) then ld x7,0(x0), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, x7=7, ld retires after 8 cycles.
REQ-040 add x0,x5,x6 -> x0 still reads 0; retire pulses once.
REQ-041 Opcode 1111111 -> halt=1 after DECODE, no further imem_req until rst; addi x5,x0,-1 with the macro undefined -> halt; with it defined -> x5=all-ones.
REQ-042 rst asserted in MEM with dmem_ack=1 in the same cycle -> no write to rd, pc=RESET_PC, retire=0.
